// File: rtl/uart_transmitter.sv
// 8N1 UART transmit stage with valid/ready byte input and internal bit timing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
    parameter int unsigned CLOCKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       serial_connection,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_index, bit_index_next;
    logic [7:0]       shift_reg, shift_reg_next;
    logic             line_next, ready_next, busy_next;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit, parity_bit_next;
`endif

    // State and registered outputs; reset forces the line high immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_index         <= '0;
            shift_reg         <= 8'h00;
            serial_connection <= 1'b1;
            data_ready        <= 1'b1;
            busy              <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit        <= 1'b0;
`endif
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            bit_index         <= bit_index_next;
            shift_reg         <= shift_reg_next;
            serial_connection <= line_next;
            data_ready        <= ready_next;
            busy              <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_bit        <= parity_bit_next;
`endif
        end
    end

    assign bit_done = (cnt == CNT_LAST);

    // Next-state and next-output logic; the counter restarts on every state change.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt + CNT_W'(1);
        bit_index_next = bit_index;
        shift_reg_next = shift_reg;
        line_next      = serial_connection;
        ready_next     = 1'b0;
        busy_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_bit_next = parity_bit;
`endif
        case (state)
            IDLE: begin
                cnt_next   = '0;
                line_next  = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
                if (data_valid && data_ready) begin
                    state_next     = START;
                    shift_reg_next = data;
                    bit_index_next = '0;
                    line_next      = 1'b0;
                    ready_next     = 1'b0;
                    busy_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_bit_next = ^data;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    line_next  = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        line_next  = parity_bit;
`else
                        state_next = STOP;
                        line_next  = 1'b1;
`endif
                    end else begin
                        shift_reg_next = {1'b0, shift_reg[7:1]};
                        line_next      = shift_reg[1];
                        bit_index_next = bit_index + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    cnt_next   = '0;
                    line_next  = 1'b1;
                end
            end
`endif
            STOP: begin
                line_next = 1'b1;
                if (bit_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                line_next  = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLOCKS_PER_BIT=4 with a loopback receiver model.
module tb_uart_transmitter;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic       clock;
    logic       reset_n;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       serial_connection;
    logic       busy;

    int tests;
    int fails;

    logic [7:0] rx_q[$];
    bit         rx_en;

    uart_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .data              (data),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .serial_connection (serial_connection),
        .busy              (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receiver model: mid-bit sampling after a falling edge on the line.
    always begin : rx_model
        logic [7:0] r;
        @(negedge serial_connection);
        if (rx_en) begin
            repeat (CPB / 2) @(posedge clock);
            if (serial_connection == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clock);
                    r[i] = serial_connection;
                end
                repeat (CPB) @(posedge clock);
                if (serial_connection == 1'b1) rx_q.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // Offers a byte and returns just after the accepting edge.
    task automatic accept(input logic [7:0] b, input string name);
        data       = b;
        data_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (data_ready === 1'b1) break;
            tick();
        end
        tests++;
        if (data_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept timeout: data_ready=%b required 1", name, data_ready);
        end
        tick();
    endtask

    // Checks line/ready/busy on every cycle of a frame, then the idle return.
    task automatic check_frame(input logic [7:0] b, input string name, input bit keep_valid,
                               input int change_at, input logic [7:0] change_to);
        logic [10:0] fr;
        logic [2:0]  exp;
        fr = make_frame(b);
        if (!keep_valid) data_valid = 1'b0;
        for (int j = 0; j < int'(NB * CPB); j++) begin
            if (j == change_at) data = change_to;
            exp = {fr[j / int'(CPB)], 1'b0, 1'b1};
            tests++;
            if ({serial_connection, data_ready, busy} !== exp) begin
                fails++;
                $display("FAIL %s cycle %0d: line,ready,busy=%b required %b", name, j,
                         {serial_connection, data_ready, busy}, exp);
            end
            tick();
        end
        tests++;
        if ({serial_connection, data_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL %s end: line,ready,busy=%b required 110", name,
                     {serial_connection, data_ready, busy});
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        data_valid = 1'b1;
        data       = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({serial_connection, data_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL reset cycle %0d: line,ready,busy=%b required 110", i,
                         {serial_connection, data_ready, busy});
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_byte();
        accept(8'hA5, "single_a5");
        tests++;
        if (make_frame(8'hA5) !== 11'b11101001010 && NB == 10) begin
            fails++;
            $display("FAIL single_a5 frame model: %b required 11101001010", make_frame(8'hA5));
        end
        check_frame(8'hA5, "single_a5", 1'b0, -1, 8'h00);
    endtask

    task automatic test_idle();
        data_valid = 1'b0;
        data       = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if ({serial_connection, data_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL idle cycle %0d: line,ready,busy=%b required 110", i,
                         {serial_connection, data_ready, busy});
            end
        end
    endtask

    task automatic test_back_to_back();
        accept(8'h00, "b2b_00");
        check_frame(8'h00, "b2b_00", 1'b1, 10, 8'hFF);
        tick();
        check_frame(8'hFF, "b2b_ff", 1'b0, 12, 8'hA5);
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q[3];
        exp_q[0] = 8'h3C;
        exp_q[1] = 8'h81;
        exp_q[2] = 8'h7E;
        rx_q.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            accept(exp_q[i], "loopback");
            data_valid = 1'b0;
            for (int n = 0; n < 100; n++) begin
                if (data_ready === 1'b1) break;
                tick();
            end
        end
        repeat (4) tick();
        rx_en = 1'b0;
        tests++;
        if (rx_q.size() != 3) begin
            fails++;
            $display("FAIL loopback count: got %0d bytes required 3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL loopback byte %0d: got %h required %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        accept(8'h55, "midreset_55");
        data_valid = 1'b0;
        repeat (17) tick();
        tests++;
        if (serial_connection !== 1'b0) begin
            fails++;
            $display("FAIL midreset bit3 before reset: line=%b required 0", serial_connection);
        end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({serial_connection, data_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL midreset async: line,ready,busy=%b required 110",
                     {serial_connection, data_ready, busy});
        end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10 * int'(CPB); i++) begin
            tick();
            tests++;
            if ({serial_connection, data_ready, busy} !== 3'b110) begin
                fails++;
                $display("FAIL midreset no-resume cycle %0d: line,ready,busy=%b required 110", i,
                         {serial_connection, data_ready, busy});
            end
        end
        accept(8'h0F, "after_reset_0f");
        check_frame(8'h0F, "after_reset_0f", 1'b0, -1, 8'h00);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        accept(8'h07, "parity_07");
        check_frame(8'h07, "parity_07", 1'b0, -1, 8'h00);
        accept(8'h03, "parity_03");
        data_valid = 1'b0;
        repeat (36) tick();
        tests++;
        if (serial_connection !== 1'b0) begin
            fails++;
            $display("FAIL parity_03 bit: line=%b required 0", serial_connection);
        end
        repeat (8) tick();
        tests++;
        if ({serial_connection, data_ready, busy} !== 3'b110) begin
            fails++;
            $display("FAIL parity_03 end: line,ready,busy=%b required 110",
                     {serial_connection, data_ready, busy});
        end
    endtask
`endif

    initial begin
        tests      = 0;
        fails      = 0;
        rx_en      = 1'b0;
        reset_n    = 1'b0;
        data       = 8'h00;
        data_valid = 1'b0;
        test_reset();
        test_single_byte();
        test_idle();
        test_back_to_back();
        test_loopback();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
